// File: rtl/quantser_pkg.sv
// Shared types and constants for the quantser packer and the benches that drive it.
package quantser_pkg;

  localparam int unsigned QP_BDOUTMAX = 32;
  localparam int unsigned MAXBDOP     = $clog2(QP_BDOUTMAX);
  localparam int unsigned QP_AW       = 9;
  localparam int unsigned QP_N        = 64;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain
  } qp_state_t;

  // One queued plane write in the default configuration.
  typedef struct packed {
    logic [QP_AW-1:0] addr;
    logic [QP_N-1:0]  data;
  } qp_entry_t;

endpackage

// File: rtl/quantser_packer_if.sv
// Valid/ready write port from the packer into bit-transposed activation memory.
interface quantser_packer_if #(
  parameter int unsigned N  = 64,
  parameter int unsigned AW = 9
) ();

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/qp_fifo.sv
// Generic synchronous FIFO; push and pop together at full count is accepted.
module qp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             single_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] PtrOne  = 1;
  localparam logic [PtrW:0]   CntOne  = 1;
  localparam logic [PtrW:0]   FullCnt = Depth[PtrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == FullCnt);
  assign single_o = (cnt_q == CntOne);
  assign do_pop   = pop_i & ~empty_o;
  assign do_push  = push_i & (~full_o | do_pop);
  // Head reads as zero when empty so the write port is quiet outside a transfer.
  assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/quantser_packer.sv
// Packs one bit per quantser lane into bit-plane words and writes them out, MSB plane first.
module quantser_packer
  import quantser_pkg::*;
#(
  parameter int unsigned N        = 64,
  parameter int unsigned BDOUTMAX = 32,
  parameter int unsigned AW       = 9,
  parameter int unsigned FDEPTH   = 4,
  localparam int unsigned BdW     = $clog2(BDOUTMAX)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                start,
  input  logic [BdW-1:0]      bdout,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW-1:0]       stride,
  input  logic [N-1:0]        din,
  quantser_packer_if.master   wr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [BdW-1:0] KOne = 1;

  qp_state_t      state_q, state_d;
  logic [BdW-1:0] k_q, k_d, bdm1_q, bdm1_d;
  logic [AW-1:0]  acc_q, acc_d, stride_q, stride_d;
  logic           err_q, err_d, done_q, done_d;

  logic           push, pop, full, empty, single;
  logic [AW+N-1:0] head;

  qp_fifo #(
    .Width (AW + N),
    .Depth (FDEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (clr),
    .push_i   (push),
    .pop_i    (pop),
    .data_i   ({acc_q, din}),
    .full_o   (full),
    .empty_o  (empty),
    .single_o (single),
    .head_o   (head)
  );

  assign wr.wr_valid             = ~empty;
  assign {wr.wr_addr, wr.wr_data} = head;
  assign pop                     = ~empty & wr.wr_ready;
  assign busy                    = (state_q != StIdle);
  assign done                    = done_q;
  assign err                     = err_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    bdm1_d   = bdm1_q;
    acc_d    = acc_q;
    stride_d = stride_q;
    err_d    = err_q;
    done_d   = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bdm1_d   = bdout;
          acc_d    = base_addr;
          stride_d = stride;
          k_d      = '0;
          state_d  = StCapture;
        end
      end
      StCapture: begin
        push  = 1'b1;
        acc_d = acc_q + stride_q;
        k_d   = k_q + KOne;
        // Full with no simultaneous pop loses this plane.
        if (full && !pop) err_d = 1'b1;
        if (start)        err_d = 1'b1;
        if (k_q == bdm1_q) state_d = StDrain;
      end
      StDrain: begin
        if (start) err_d = 1'b1;
        // Leave as the final transfer completes so done and busy move together.
        if (empty || (single && pop)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      bdm1_q   <= '0;
      acc_q    <= '0;
      stride_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (clr) begin
      state_q  <= StIdle;
      k_q      <= '0;
      bdm1_q   <= '0;
      acc_q    <= '0;
      stride_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      bdm1_q   <= bdm1_d;
      acc_q    <= acc_d;
      stride_q <= stride_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_quantser_packer.sv
// Randomised scoreboard bench for quantser_packer with a queue-level reference model.
module tb_quantser_packer;

  localparam int unsigned N        = 8;
  localparam int unsigned AW       = 9;
  localparam int unsigned FDEPTH   = 4;
  localparam int unsigned BDOUTMAX = 32;
  localparam int unsigned BdW      = 5;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b1;
  logic           clr       = 1'b0;
  logic           start     = 1'b0;
  logic [BdW-1:0] bdout     = '0;
  logic [AW-1:0]  base_addr = '0;
  logic [AW-1:0]  stride    = '0;
  logic [N-1:0]   din       = '0;
  logic           busy, done, err;

  quantser_packer_if #(.N(N), .AW(AW)) wr_if ();

  quantser_packer #(
    .N        (N),
    .BDOUTMAX (BDOUTMAX),
    .AW       (AW),
    .FDEPTH   (FDEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .start     (start),
    .bdout     (bdout),
    .base_addr (base_addr),
    .stride    (stride),
    .din       (din),
    .wr        (wr_if),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [N-1:0]  d;
  } wr_t;

  wr_t        expq[$];
  int         n_cmp    = 0;
  int         n_fail   = 0;
  int         n_acc    = 0;
  bit         err_m    = 1'b0;
  bit         hold_chk = 1'b1;
  bit         use_tab  = 1'b0;
  logic [7:0] tab [4]  = '{8'hA5, 8'h3C, 8'hFF, 8'h01};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Ready schedule as seen at capture/drain edge index e (E0 = start edge).
  function automatic bit rdy(input int mode, input int e);
    case (mode)
      0:       return 1'b1;
      1:       return (e % 2) == 1;
      2:       return e > 6;
      default: return 1'(($urandom_range(0, 1)));
    endcase
  endfunction

  // Monitor: scoreboard on accepted writes plus head stability while stalled.
  bit  stall = 1'b0;
  wr_t stall_w;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall && hold_chk) begin
        chk("stall_valid", 64'(wr_if.wr_valid), 64'd1);
        chk("stall_addr", 64'(wr_if.wr_addr), 64'(stall_w.a));
        chk("stall_data", 64'(wr_if.wr_data), 64'(stall_w.d));
      end
      if (wr_if.wr_valid && wr_if.wr_ready) begin
        stall = 1'b0;
        n_acc++;
        if (expq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected none",
                   wr_if.wr_addr, wr_if.wr_data);
        end else begin
          wr_t w;
          w = expq.pop_front();
          chk("wr_addr", 64'(wr_if.wr_addr), 64'(w.a));
          chk("wr_data", 64'(wr_if.wr_data), 64'(w.d));
        end
      end else if (wr_if.wr_valid) begin
        stall   = 1'b1;
        stall_w = '{a: wr_if.wr_addr, d: wr_if.wr_data};
      end else begin
        stall = 1'b0;
      end
    end
  end

  // One job; called and returns at posedge+1. inj >= 0 pulses start during capture k=inj.
  task automatic run_job(input int bdo, input logic [AW-1:0] base, input logic [AW-1:0] strd,
                         input int mode, input int inj);
    int            bd;
    int            occ;
    int            e;
    bit            r, pp, got;
    logic [AW-1:0] a_m;
    bd  = bdo + 1;
    occ = 0;
    a_m = base;
    start = 1'b1; bdout = BdW'(bdo); base_addr = base; stride = strd;
    wr_if.wr_ready = rdy(mode, 0);
    @(posedge clk); #1;
    for (int k = 0; k < bd; k++) begin
      if (k == inj) begin
        start = 1'b1;
        bdout = BdW'($urandom);
        err_m = 1'b1;
      end else begin
        start = 1'b0;
      end
      din = use_tab ? tab[k] : N'($urandom);
      r   = rdy(mode, k + 1);
      wr_if.wr_ready = r;
      pp  = (occ > 0) && r;
      if (occ < FDEPTH || pp) begin
        expq.push_back('{a: a_m, d: din});
        occ++;
      end else begin
        err_m = 1'b1;
      end
      if (pp) occ--;
      a_m = a_m + strd;
      @(posedge clk); #1;
      chk("busy_capture", 64'(busy), 64'd1);
    end
    start = 1'b0;
    got   = 1'b0;
    e     = bd + 1;
    while (!got && e < bd + 200) begin
      r = rdy(mode, e);
      wr_if.wr_ready = r;
      if (occ > 0 && r) occ--;
      @(posedge clk); #1;
      if (occ == 0) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_low", 64'(busy), 64'd0);
        chk("err_flag", 64'(err), 64'(err_m));
        got = 1'b1;
      end else begin
        chk("done_early", 64'(done), 64'd0);
      end
      e++;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got no completion, expected done within 200 cycles");
    end
    @(posedge clk); #1;
    chk("done_single", 64'(done), 64'd0);
    chk("all_writes_seen", 64'(expq.size()), 64'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr   = 1'b0;
    err_m = 1'b0;
    chk("err_after_clr", 64'(err), 64'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 64'(wr_if.wr_valid), 64'd0);
    chk({tag, "_addr"}, 64'(wr_if.wr_addr), 64'd0);
    chk({tag, "_data"}, 64'(wr_if.wr_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    wr_if.wr_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed pattern from four known planes.
    use_tab = 1'b1;
    run_job(3, 9'h010, 9'h001, 0, -1);
    use_tab = 1'b0;

    // Single-plane job, then two planes with address wrap.
    run_job(0, 9'h1FF, 9'h002, 0, -1);
    run_job(1, 9'h1FF, 9'h002, 0, -1);

    // Backpressure overflow drops planes 4 and 5.
    run_job(7, AW'($urandom), AW'($urandom), 2, -1);
    do_clr();

    // Alternating ready: stalls without drops.
    run_job(3, AW'($urandom), AW'($urandom), 1, -1);

    // Start during capture is ignored but flagged.
    run_job(5, AW'($urandom), AW'($urandom), 0, 2);
    do_clr();

    // Clear sampled at E2 aborts the job.
    hold_chk = 1'b0;
    wr_if.wr_ready = 1'b0;
    start = 1'b1; bdout = 5'd3; base_addr = 9'h020; stride = 9'h001;
    @(posedge clk); #1;
    start = 1'b0; din = N'($urandom);
    @(posedge clk); #1;
    din = N'($urandom); clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk_quiet("clr_abort");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("clr_no_done", 64'(done), 64'd0);
    end
    hold_chk = 1'b1;

    // Async reset in DRAIN with two planes queued.
    hold_chk = 1'b0;
    start = 1'b1; bdout = 5'd1; base_addr = 9'h040; stride = 9'h003;
    @(posedge clk); #1;
    start = 1'b0; din = N'($urandom);
    @(posedge clk); #1;
    din = N'($urandom);
    @(posedge clk); #1;
    chk("drain_queued_valid", 64'(wr_if.wr_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    @(posedge clk); #1;
    rst_n    = 1'b1;
    err_m    = 1'b0;
    hold_chk = 1'b1;
    expq.delete();

    // Maximum bit depth after reset: exactly 32 writes.
    n_acc = 0;
    run_job(31, AW'($urandom), AW'($urandom), 0, -1);
    chk("writes_bd32", 64'(n_acc), 64'd32);

    // Random jobs under random backpressure.
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(0, 31)), AW'($urandom), AW'($urandom), 3, -1);
      do_clr();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
